// File: rtl/mips_enc_pkg.sv
// Shared types for the MIPS instruction encoder: op kinds, opcode constants, FSM states.
package mips_enc_pkg;

    typedef enum logic [2:0] {
        OP_RTYPE = 3'd0,
        OP_ADDI  = 3'd1,
        OP_BEQ   = 3'd2,
        OP_J     = 3'd3,
        OP_JAL   = 3'd4,
        OP_SW    = 3'd5,
        OP_LW    = 3'd6,
        OP_RES   = 3'd7
    } op_kind_e;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_JAL   = 6'b000011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_RES   = 6'b111111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } enc_state_e;

endpackage

// File: rtl/mips_instr_pack.sv
// Pure combinational packing of one request into a 32-bit MIPS word.
// Op 7 (RES) encodes only when MIPS_ENC_RES_EN is defined; otherwise it is illegal.
module mips_instr_pack
    import mips_enc_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_shamt,
    input  logic [5:0]  i_funct,
    input  logic [15:0] i_imm,
    input  logic [25:0] i_target,
    output logic [31:0] o_word,
    output logic        o_legal
);

    // Select the field layout for the requested op kind.
    always_comb begin
        o_word  = 32'd0;
        o_legal = 1'b1;
        case (op_kind_e'(i_op))
            OP_RTYPE: o_word = {OPC_RTYPE, i_rs, i_rt, i_rd, i_shamt, i_funct};
            OP_ADDI:  o_word = {OPC_ADDI, i_rs, i_rt, i_imm};
            OP_BEQ:   o_word = {OPC_BEQ, i_rs, i_rt, i_imm};
            OP_J:     o_word = {OPC_J, i_target};
            OP_JAL:   o_word = {OPC_JAL, i_target};
            OP_SW:    o_word = {OPC_SW, i_rs, i_rt, i_imm};
            OP_LW:    o_word = {OPC_LW, i_rs, i_rt, i_imm};
            OP_RES: begin
`ifdef MIPS_ENC_RES_EN
                o_word  = {OPC_RES, 26'd0};
                o_legal = 1'b1;
`else
                o_word  = 32'd0;
                o_legal = 1'b0;
`endif
            end
            default: begin
                o_word  = 32'd0;
                o_legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// Load-session controller writing encoded MIPS instructions into instruction memory.
// Optional feature: MIPS_ENC_RES_EN enables encoding of op 7 (RES).
module mips_instr_encoder
    import mips_enc_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        finish,
    input  logic [5:0]  base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic        im_we,
    output logic [5:0]  im_addr,
    output logic [31:0] im_wd,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic [6:0]  count
);

    localparam logic [6:0] DEPTH_C = 7'(DEPTH);

    enc_state_e  r_state;
    enc_state_e  w_next_state;
    logic [5:0]  r_ptr;
    logic [6:0]  r_count;
    logic        r_done;
    logic        r_im_we;
    logic [5:0]  r_im_addr;
    logic [31:0] r_im_wd;
    logic        r_illegal;

    logic [31:0] w_word;
    logic        w_legal;
    logic        w_accept;
    logic        w_write;
    logic [6:0]  w_count_inc;
    logic        w_fill;

    mips_instr_pack u_pack (
        .i_op     (op),
        .i_rs     (rs),
        .i_rt     (rt),
        .i_rd     (rd),
        .i_shamt  (shamt),
        .i_funct  (funct),
        .i_imm    (imm),
        .i_target (target),
        .o_word   (w_word),
        .o_legal  (w_legal)
    );

    // Session control pulses take priority over requests, so ready drops while they are high.
    assign in_ready    = (r_state == ST_LOAD) & ~start & ~finish;
    assign w_accept    = in_valid & in_ready;
    assign w_write     = w_accept & w_legal;
    assign w_count_inc = r_count + 7'd1;
    assign w_fill      = w_write & (w_count_inc == DEPTH_C);

    assign busy    = (r_state == ST_LOAD);
    assign done    = r_done;
    assign count   = r_count;
    assign im_we   = r_im_we;
    assign im_addr = r_im_addr;
    assign im_wd   = r_im_wd;
    assign illegal = r_illegal;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next_state = ST_LOAD;
                else       w_next_state = ST_IDLE;
            end
            ST_LOAD: begin
                if (start)       w_next_state = ST_LOAD;
                else if (finish) w_next_state = ST_IDLE;
                else if (w_fill) w_next_state = ST_FULL;
                else             w_next_state = ST_LOAD;
            end
            ST_FULL: begin
                if (start)       w_next_state = ST_LOAD;
                else if (finish) w_next_state = ST_IDLE;
                else             w_next_state = ST_FULL;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Write port, pointer, counter and status registers; a write never coincides with start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr     <= 6'd0;
            r_count   <= 7'd0;
            r_done    <= 1'b0;
            r_im_we   <= 1'b0;
            r_im_addr <= 6'd0;
            r_im_wd   <= 32'd0;
            r_illegal <= 1'b0;
        end else begin
            r_im_we   <= w_write;
            r_illegal <= w_accept & ~w_legal;
            if (w_write) begin
                r_im_addr <= r_ptr;
                r_im_wd   <= w_word;
                r_ptr     <= r_ptr + 6'd1;
                r_count   <= w_count_inc;
            end else if (start) begin
                r_ptr     <= base_addr;
                r_count   <= 7'd0;
            end else begin
                r_ptr     <= r_ptr;
                r_count   <= r_count;
            end
            if (start) begin
                r_done <= 1'b0;
            end else if ((r_state == ST_LOAD) && (finish || w_fill)) begin
                r_done <= 1'b1;
            end else begin
                r_done <= r_done;
            end
        end
    end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder (DEPTH=4): directed scenarios then random traffic.
module tb_mips_instr_encoder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, finish, in_valid;
    logic [5:0]  base_addr;
    logic [2:0]  op;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic        in_ready, im_we, busy, done, illegal;
    logic [5:0]  im_addr;
    logic [31:0] im_wd;
    logic [6:0]  count;

    int total = 0;
    int bad   = 0;

    // Reference model state: 0 idle, 1 load, 2 full.
    int          m_state, m_ptr, m_count;
    bit          m_done;
    bit          e_we, e_ill;
    logic [5:0]  e_addr;
    logic [31:0] e_wd;

    always #5 clk = ~clk;

    mips_instr_encoder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
        .base_addr(base_addr), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm(imm), .target(target), .im_we(im_we), .im_addr(im_addr),
        .im_wd(im_wd), .busy(busy), .done(done), .illegal(illegal), .count(count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Encoding computed arithmetically from the field positions of the MIPS formats.
    function automatic void ref_enc(input int o, output logic [31:0] w, output bit leg);
        int unsigned opc [8] = '{0, 8, 4, 2, 3, 43, 35, 63};
        longint unsigned v;
        v   = longint'(opc[o]) * 64'd67108864;
        leg = 1'b1;
        if (o == 0)
            v += rs * 2097152 + rt * 65536 + rd * 2048 + shamt * 64 + funct;
        else if (o == 3 || o == 4)
            v += target;
        else if (o == 7) begin
`ifndef MIPS_ENC_RES_EN
            leg = 1'b0;
`endif
        end else
            v += rs * 2097152 + rt * 65536 + imm;
        w = v[31:0];
    endfunction

    task automatic idle_in();
        start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    endtask

    task automatic req(input int o, input int a, input int b, input int c,
                       input int s, input int f, input int i, input int t);
        in_valid = 1'b1; op = 3'(o); rs = 5'(a); rt = 5'(b); rd = 5'(c);
        shamt = 5'(s); funct = 6'(f); imm = 16'(i); target = 26'(t);
    endtask

    task automatic model_reset();
        m_state = 0; m_ptr = 0; m_count = 0; m_done = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_we"},    32'(im_we),    32'd0);
        chk({tag, "_rdy"},   32'(in_ready), 32'd0);
        chk({tag, "_busy"},  32'(busy),     32'd0);
        chk({tag, "_done"},  32'(done),     32'd0);
        chk({tag, "_ill"},   32'(illegal),  32'd0);
        chk({tag, "_count"}, 32'(count),    32'd0);
        chk({tag, "_addr"},  32'(im_addr),  32'd0);
        chk({tag, "_wd"},    im_wd,         32'd0);
    endtask

    // One clock: check ready, advance the model over the edge, check registered outputs.
    task automatic tick();
        bit rdy, leg;
        logic [31:0] w;
        #1;
        rdy = (m_state == 1) && !start && !finish;
        chk("in_ready", 32'(in_ready), 32'(rdy));
        e_we = 1'b0; e_ill = 1'b0;
        if (rdy && in_valid) begin
            ref_enc(int'(op), w, leg);
            if (leg) begin
                e_we = 1'b1; e_addr = 6'(m_ptr); e_wd = w;
                m_ptr = (m_ptr + 1) % 64;
                m_count++;
                if (m_count == DEPTH) begin m_state = 2; m_done = 1'b1; end
            end else begin
                e_ill = 1'b1;
            end
        end else if (start) begin
            m_ptr = int'(base_addr); m_count = 0; m_done = 1'b0; m_state = 1;
        end else if (finish && m_state == 1) begin
            m_done = 1'b1; m_state = 0;
        end else if (finish && m_state == 2) begin
            m_state = 0;
        end
        @(posedge clk);
        #1;
        chk("im_we",   32'(im_we),   32'(e_we));
        chk("illegal", 32'(illegal), 32'(e_ill));
        chk("count",   32'(count),   32'(m_count));
        chk("busy",    32'(busy),    32'(m_state == 1));
        chk("done",    32'(done),    32'(m_done));
        if (e_we) begin
            chk("im_addr", 32'(im_addr), 32'(e_addr));
            chk("im_wd",   im_wd,        e_wd);
        end
    endtask

    initial begin
        rst_n = 1'b0; base_addr = 6'd0;
        idle_in();
        req(0, 0, 0, 0, 0, 0, 0, 0);
        in_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Session at 0: ADDI, then RTYPE and LW back-to-back.
        start = 1'b1; base_addr = 6'd0;
        tick();
        start = 1'b0;
        req(1, 0, 8, 0, 0, 0, 5, 0);
        tick();
        chk("addi_wd", im_wd, 32'h20080005);
        chk("addi_addr", 32'(im_addr), 32'd0);
        chk("addi_count", 32'(count), 32'd1);
        req(0, 8, 9, 10, 0, 32'h20, 0, 0);
        tick();
        chk("rtype_wd", im_wd, 32'h01095020);
        chk("rtype_addr", 32'(im_addr), 32'd1);
        req(6, 29, 9, 0, 0, 0, 4, 0);
        tick();
        chk("lw_wd", im_wd, 32'h8FA90004);
        chk("lw_addr", 32'(im_addr), 32'd2);
        chk("lw_we", 32'(im_we), 32'd1);
        idle_in(); finish = 1'b1;
        tick();
        finish = 1'b0;

        // Pointer wrap and fill at base 62.
        start = 1'b1; base_addr = 6'd62;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req(3, 0, 0, 0, 0, 0, 0, 32'h10);
            tick();
            chk("wrap_wd", im_wd, 32'h08000010);
            chk("wrap_addr", 32'(im_addr), 32'((62 + k) % 64));
        end
        chk("full_ready", 32'(in_ready), 32'd0);
        chk("full_done", 32'(done), 32'd1);
        tick();
        idle_in(); finish = 1'b1;
        tick();
        finish = 1'b0;

        // Op 7 handling.
        start = 1'b1; base_addr = 6'd10;
        tick();
        start = 1'b0;
        req(7, 0, 0, 0, 0, 0, 0, 0);
        tick();
`ifdef MIPS_ENC_RES_EN
        chk("res_wd", im_wd, 32'hFC000000);
        chk("res_we", 32'(im_we), 32'd1);
`else
        chk("res_ill", 32'(illegal), 32'd1);
        chk("res_count", 32'(count), 32'd0);
`endif
        in_valid = 1'b0;
        tick();

        // Finish right after an accept: write completes, then idle.
        req(1, 1, 2, 0, 0, 0, 16'h1234, 0);
        tick();
        chk("fin_we", 32'(im_we), 32'd1);
        idle_in(); finish = 1'b1;
        tick();
        finish = 1'b0;
        chk("fin_done", 32'(done), 32'd1);
        chk("fin_busy", 32'(busy), 32'd0);

        // Reset right after an accept aborts the write.
        start = 1'b1; base_addr = 6'd5;
        tick();
        start = 1'b0;
        req(5, 3, 4, 0, 0, 0, 8, 0);
        tick();
        idle_in();
        #1 rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst");
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            start  = (r < 5);
            finish = (r >= 5 && r < 9);
            base_addr = ($urandom_range(0, 1) == 0) ? 6'(60 + $urandom_range(0, 3)) : 6'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            op = 3'($urandom); rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
            shamt = 5'($urandom); funct = 6'($urandom); imm = 16'($urandom);
            target = 26'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
